// File: rtl/regfile_sched_if.sv
// Bus bundle between the register-file access scheduler and its requesters.
// master: the scheduler side; slave: requesters plus register file side.
interface regfile_sched_if #(
    parameter int unsigned num_req = 3
);
    localparam int unsigned sel_w = $clog2(num_req);

    logic [num_req-1:0] req;
    logic [num_req-1:0] ack;
    logic               rd_req;
    logic               rd_gnt;
    logic               rf_wen;
    logic [sel_w-1:0]   rf_wsel;
    logic               rf_ren;
    logic               rf_wr_done;
    logic               busy;
    logic               err;

    modport master (
        input  req, rd_req, rf_wr_done,
        output ack, rd_gnt, rf_wen, rf_wsel, rf_ren, busy, err
    );

    modport slave (
        output req, rd_req, rf_wr_done,
        input  ack, rd_gnt, rf_wen, rf_wsel, rf_ren, busy, err
    );
endinterface

// File: rtl/regfile_sched.sv
// Tile register-file access scheduler: round-robin writes, prioritised read windows
// with a starvation bound. Optional write watchdog enabled by RF_SCHED_WATCHDOG_EN.
module regfile_sched #(
    parameter int unsigned num_req = 3,
    parameter int unsigned max_rd  = 8,
    parameter int unsigned timeout = 15
) (
    input logic             clk,
    input logic             reset,
    regfile_sched_if.master bus
);
    localparam int unsigned sel_w   = $clog2(num_req);
    // One width serves both the read-window counter and the watchdog counter.
    localparam int unsigned cnt_top = (max_rd > timeout) ? max_rd : timeout;
    localparam int unsigned cnt_w   = $clog2(cnt_top + 1);

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    state_t             state, next_state;
    logic [sel_w-1:0]   ptr;
    logic [sel_w-1:0]   winner;
    logic [sel_w-1:0]   pick;
    logic               pick_valid;
    int unsigned        idx;
    logic               any_req;
    logic [cnt_w-1:0]   rd_cnt;
    logic               lockout;
    logic               rd_limit;
    logic               wd_expire;

    logic [num_req-1:0] ack_d,  ack_q;
    logic               rd_gnt_d, rd_gnt_q;
    logic               rf_wen_d, rf_wen_q;
    logic               rf_ren_d, rf_ren_q;
    logic               busy_d,   busy_q;

    assign any_req  = |bus.req;
    assign rd_limit = any_req && ((rd_cnt + cnt_w'(1)) == cnt_w'(max_rd));

    // First set request at or after the pointer, wrapping around.
    always_comb begin
        pick       = ptr;
        pick_valid = 1'b0;
        idx        = 0;
        for (int unsigned i = 0; i < num_req; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= num_req) idx = idx - num_req;
            if (!pick_valid && bus.req[idx[sel_w-1:0]]) begin
                pick       = idx[sel_w-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.rd_req && !lockout) next_state = RD;
                else if (pick_valid)        next_state = WR;
            end
            RD:      if (!bus.rd_req || rd_limit) next_state = IDLE;
            WR:      if (bus.rf_wr_done || wd_expire) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        ack_d    = '0;
        rd_gnt_d = 1'b0;
        rf_wen_d = 1'b0;
        rf_ren_d = 1'b0;
        busy_d   = (next_state != IDLE);
        case (next_state)
            RD: begin
                rd_gnt_d = 1'b1;
                rf_ren_d = 1'b1;
            end
            WR:  rf_wen_d = 1'b1;
            ACK: if (bus.rf_wr_done) ack_d = num_req'(1) << winner;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q    <= '0;
            rd_gnt_q <= 1'b0;
            rf_wen_q <= 1'b0;
            rf_ren_q <= 1'b0;
            busy_q   <= 1'b0;
            winner   <= '0;
            ptr      <= '0;
            rd_cnt   <= '0;
            lockout  <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            rd_gnt_q <= rd_gnt_d;
            rf_wen_q <= rf_wen_d;
            rf_ren_q <= rf_ren_d;
            busy_q   <= busy_d;
            if (state == IDLE && next_state == WR) winner <= pick;
            if (state == RD && any_req) rd_cnt <= rd_cnt + cnt_w'(1);
            if (state == RD && rd_limit) lockout <= 1'b1;
            if (state == ACK) begin
                ptr     <= (winner == sel_w'(num_req - 1)) ? '0 : winner + sel_w'(1);
                rd_cnt  <= '0;
                lockout <= 1'b0;
            end
        end
    end

`ifdef RF_SCHED_WATCHDOG_EN
    logic [cnt_w-1:0] wd_cnt;
    logic             err_q;

    assign wd_expire = (state == WR) && !bus.rf_wr_done &&
                       ((wd_cnt + cnt_w'(1)) == cnt_w'(timeout));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == WR) ? wd_cnt + cnt_w'(1) : '0;
            if (wd_expire) err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign wd_expire = 1'b0;
    assign bus.err   = 1'b0;
`endif

    assign bus.ack     = ack_q;
    assign bus.rd_gnt  = rd_gnt_q;
    assign bus.rf_wen  = rf_wen_q;
    assign bus.rf_wsel = winner;
    assign bus.rf_ren  = rf_ren_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_regfile_sched.sv
// Randomised scoreboard bench for regfile_sched against a cycle-level reference model.
// Models the watchdog when RF_SCHED_WATCHDOG_EN is defined.
module tb_regfile_sched;
    localparam int N       = 3;
    localparam int MAX_RD  = 8;
    localparam int TIMEOUT = 15;
    localparam int CYCLES  = 1500;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_sched_if #(.num_req(N)) bus ();

    regfile_sched #(
        .num_req(N),
        .max_rd (MAX_RD),
        .timeout(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [N-1:0] ack;
        logic         rd_gnt;
        logic         rf_ren;
        logic         rf_wen;
        logic         busy;
        logic         err;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t         exp_q[$];
    int           grant_q[$];
    logic [N-1:0] ackx_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the register file (reader, writer k, committing k).
    bit           m_rd;
    int           m_wr;
    int           m_commit;
    bit           m_pulse;
    int           m_ptr;
    int           m_rdcnt;
    bit           m_lock;
    int           m_wd;
    bit           m_err;
    logic [N-1:0] m_ack;

    task automatic model_reset();
        m_rd = 0; m_wr = -1; m_commit = -1; m_pulse = 0;
        m_ptr = 0; m_rdcnt = 0; m_lock = 0; m_wd = 0; m_err = 0; m_ack = '0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic rq, input logic dn);
        exp_t e;
        if (m_commit >= 0) begin
            m_ptr    = (m_commit + 1) % N;
            m_rdcnt  = 0;
            m_lock   = 0;
            m_commit = -1;
        end else if (m_rd) begin
            if (r != 0) m_rdcnt++;
            if (r != 0 && m_rdcnt == MAX_RD) begin
                m_lock = 1;
                m_rd   = 0;
            end else if (!rq) begin
                m_rd = 0;
            end
        end else if (m_wr >= 0) begin
            if (dn) begin
                m_commit = m_wr; m_pulse = 1; m_wr = -1;
            end
`ifdef RF_SCHED_WATCHDOG_EN
            else begin
                m_wd++;
                if (m_wd == TIMEOUT) begin
                    m_commit = m_wr; m_pulse = 0; m_err = 1; m_wr = -1;
                end
            end
`endif
        end else if (rq && !m_lock) begin
            m_rd = 1;
        end else if (r != 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (r[c] && m_wr < 0) m_wr = c;
            end
            m_wd = 0;
            grant_q.push_back(m_wr);
        end
        e.cyc      = cyc + 1;
        e.o.ack    = (m_commit >= 0 && m_pulse) ? (N'(1) << m_commit) : '0;
        e.o.rd_gnt = m_rd;
        e.o.rf_ren = m_rd;
        e.o.rf_wen = (m_wr >= 0);
        e.o.busy   = m_rd || (m_wr >= 0) || (m_commit >= 0);
        e.o.err    = m_err;
        if (e.o.ack != 0) ackx_q.push_back(e.o.ack);
        m_ack = e.o.ack;
        exp_q.push_back(e);
    endtask

    logic [N-1:0] req_v  = '0;
    logic         rd_v   = 1'b0;
    logic         done_v = 1'b0;

    // Drive one cycle of stimulus (requesters drop req the cycle their ack shows).
    task automatic cycle_step(input int n);
        logic [N-1:0] just;
        just  = m_ack;
        req_v = req_v & ~just;
        if (n == 0) req_v = req_v | N'(1);
        else if (n == 12) req_v = req_v | ({N{1'b1}} & ~just);
        else if (n >= 40) begin
            for (int k = 0; k < N; k++)
                if (!req_v[k] && !just[k] && $urandom_range(3) == 0) req_v[k] = 1'b1;
        end
        if (n < 40) rd_v = 1'b0;
        else if (n >= 300 && n < 370) rd_v = 1'b1;
        else if (rd_v) rd_v = ($urandom_range(4) != 0);
        else rd_v = ($urandom_range(7) == 0);
        if (n < 40) done_v = 1'b1;
        else if (n >= 400 && n < 440) done_v = 1'b0;
        else done_v = ($urandom_range(2) == 0);
        bus.req        = req_v;
        bus.rd_req     = rd_v;
        bus.rf_wr_done = done_v;
        model_step(req_v, rd_v, done_v);
    endtask

    obs_t         o_act;
    exp_t         e_cur;
    logic         prev_wen = 1'b0;
    int           cur_grant = 0;
    logic [N-1:0] ack_exp;

    always @(negedge clk) begin
        if (mon_en) begin
            o_act = '{ack: bus.ack, rd_gnt: bus.rd_gnt, rf_ren: bus.rf_ren,
                      rf_wen: bus.rf_wen, busy: bus.busy, err: bus.err};
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e_cur = exp_q.pop_front();
                chk("cycle_outputs", 32'(o_act), 32'(e_cur.o));
            end
            if (bus.rf_wen && !prev_wen) begin
                if (grant_q.size() == 0) chk("grant_unexpected", 32'(bus.rf_wsel), 32'hFFFF_FFFF);
                else cur_grant = grant_q.pop_front();
            end
            if (bus.rf_wen) chk("rf_wsel", 32'(bus.rf_wsel), 32'(cur_grant));
            if (bus.ack != 0) begin
                if (ackx_q.size() == 0) chk("ack_unexpected", 32'(bus.ack), 32'h0);
                else begin
                    ack_exp = ackx_q.pop_front();
                    chk("ack_pulse", 32'(bus.ack), 32'(ack_exp));
                end
            end
            prev_wen = bus.rf_wen;
        end
    end

    bit did_reset = 1'b0;

    initial begin
        bus.req        = '0;
        bus.rd_req     = 1'b0;
        bus.rf_wr_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", 32'({bus.ack, bus.rd_gnt, bus.rf_ren, bus.rf_wen, bus.rf_wsel, bus.busy, bus.err}), 32'h0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int n = 0; n < CYCLES; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (n >= 900 && !did_reset && m_wr >= 0) begin
                did_reset = 1'b1;
                #5;
                reset = 1'b1;
                #1;
                chk("reset_async", 32'({bus.ack, bus.rd_gnt, bus.rf_ren, bus.rf_wen, bus.rf_wsel, bus.busy, bus.err}), 32'h0);
                @(posedge clk); #1;
                reset = 1'b0;
                model_reset();
            end
            cycle_step(n);
        end
        repeat (3) @(negedge clk);
        chk("reset_mid_write_seen", 32'(did_reset), 32'h1);
        chk("grant_queue_drained", 32'(grant_q.size()), 32'h0);
        chk("ack_queue_drained", 32'(ackx_q.size()), 32'h0);
        chk("cycle_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
